// File: rtl/core_debug_pkg.sv
// core_debug_pkg: opcodes, FSM state codes and error classification shared by the debug unit.
package core_debug_pkg;

    localparam logic [3:0] CMD_READ  = 4'h0;
    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_GO    = 4'h8;
    localparam logic [3:0] CMD_STEP  = 4'hA;
    localparam logic [3:0] CMD_STOP  = 4'hF;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD        = 3'd1;
    localparam logic [2:0] ST_WR_WAIT   = 3'd2;
    localparam logic [2:0] ST_CORE_WAIT = 3'd3;
    localparam logic [2:0] ST_STEP_WAIT = 3'd4;
    localparam logic [2:0] ST_STEP_GAP  = 3'd5;
    localparam logic [2:0] ST_ERR       = 3'd6;
    localparam logic [2:0] ST_RESP      = 3'd7;

    typedef enum logic [1:0] {E_NONE, E_OPCODE, E_TARGET, E_STATE} err_e;

    function automatic err_e cmd_err(input logic [3:0] cmd, input logic stopped, input logic hit);
        if (cmd == CMD_GO || cmd == CMD_STOP) return E_NONE;
        if (cmd == CMD_STEP) return stopped ? E_NONE : E_STATE;
        if (cmd != CMD_READ && cmd != CMD_WRITE) return E_OPCODE;
        if (!stopped) return E_STATE;
        return hit ? E_NONE : E_TARGET;
    endfunction

endpackage

// File: rtl/core_debug_if.sv
// core_debug_if: command, core-control and register-file signals of the debug unit.
interface core_debug_if #(
    parameter int P_DATA_W   = 32,
    parameter int P_TARGET_W = 12,
    parameter int P_REG_N    = 38
);
    logic                          iCMD_REQ;
    logic                          oCMD_BUSY;
    logic [3:0]                    iCMD_COMMAND;
    logic [P_TARGET_W-1:0]         iCMD_TARGET;
    logic [P_DATA_W-1:0]           iCMD_DATA;
    logic                          oRESP_VALID;
    logic                          oRESP_ERROR;
    logic [P_DATA_W-1:0]           oRESP_DATA;
    logic                          oDEBUG_CORE_REQ;
    logic                          oDEBUG_CORE_STOP;
    logic                          oDEBUG_CORE_START;
    logic                          oDEBUG_CORE_STEP;
    logic                          iDEBUG_CORE_ACK;
    logic [P_REG_N*P_DATA_W-1:0]   iREG_R_DATA;
    logic                          oREG_W_VALID;
    logic [P_TARGET_W-1:0]         oREG_W_TARGET;
    logic [P_DATA_W-1:0]           oREG_W_DATA;
    logic                          iREG_W_ACK;
    logic                          oCORE_STOPPED;

    modport slave (
        input  iCMD_REQ, iCMD_COMMAND, iCMD_TARGET, iCMD_DATA, iDEBUG_CORE_ACK, iREG_R_DATA, iREG_W_ACK,
        output oCMD_BUSY, oRESP_VALID, oRESP_ERROR, oRESP_DATA, oDEBUG_CORE_REQ, oDEBUG_CORE_STOP,
               oDEBUG_CORE_START, oDEBUG_CORE_STEP, oREG_W_VALID, oREG_W_TARGET, oREG_W_DATA, oCORE_STOPPED
    );

    modport master (
        output iCMD_REQ, iCMD_COMMAND, iCMD_TARGET, iCMD_DATA, iDEBUG_CORE_ACK, iREG_R_DATA, iREG_W_ACK,
        input  oCMD_BUSY, oRESP_VALID, oRESP_ERROR, oRESP_DATA, oDEBUG_CORE_REQ, oDEBUG_CORE_STOP,
               oDEBUG_CORE_START, oDEBUG_CORE_STEP, oREG_W_VALID, oREG_W_TARGET, oREG_W_DATA, oCORE_STOPPED
    );

endinterface

// File: rtl/core_debug_regsel.sv
// core_debug_regsel: selects one register from the flattened snapshot and flags whether the index exists.
module core_debug_regsel #(
    parameter int P_DATA_W   = 32,
    parameter int P_TARGET_W = 12,
    parameter int P_REG_N    = 38
) (
    input  logic [P_REG_N*P_DATA_W-1:0] reg_data,
    input  logic [P_TARGET_W-1:0]       target,
    output logic [P_DATA_W-1:0]         sel_data,
    output logic                        in_range
);

    always_comb begin
        sel_data = '0;
        in_range = 1'b0;
        for (int k = 0; k < P_REG_N; k++) begin
            if (target == P_TARGET_W'(k)) begin
                sel_data = reg_data[k*P_DATA_W +: P_DATA_W];
                in_range = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_debug_unit.sv
// core_debug_unit: one-at-a-time debug command engine driving core run/stop/step and register access.
module core_debug_unit
    import core_debug_pkg::*;
#(
    parameter int P_DATA_W           = 32,
    parameter int P_TARGET_W         = 12,
    parameter int P_REG_N            = 38,
    parameter int P_STEP_W           = 8,
    parameter bit P_STOPPED_AT_RESET = 1'b0
) (
    input logic       iCLOCK,
    input logic       inRESET,
    core_debug_if.slave dbg
);

    logic [2:0]            state_q, state_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [P_TARGET_W-1:0] target_q, target_d;
    logic [P_DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [P_STEP_W-1:0]   remain_q, remain_d, done_q, done_d;
    logic                  stopped_q, stopped_d;
    logic [P_DATA_W-1:0]   sel_data;
    logic                  in_range, accept;
    logic [P_STEP_W-1:0]   step_cnt;
    err_e                  err;

    core_debug_regsel #(
        .P_DATA_W  (P_DATA_W),
        .P_TARGET_W(P_TARGET_W),
        .P_REG_N   (P_REG_N)
    ) u_regsel (
        .reg_data(dbg.iREG_R_DATA),
        .target  (dbg.iCMD_TARGET),
        .sel_data(sel_data),
        .in_range(in_range)
    );

    assign accept   = dbg.iCMD_REQ && state_q == ST_IDLE;
    assign err      = cmd_err(dbg.iCMD_COMMAND, stopped_q, in_range);
    assign step_cnt = dbg.iCMD_DATA[P_STEP_W-1:0] == '0 ? P_STEP_W'(1) : dbg.iCMD_DATA[P_STEP_W-1:0];

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        target_d  = target_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        remain_d  = remain_q;
        done_d    = done_q;
        stopped_d = stopped_q;
        if (accept) begin
            state_d  = err != E_NONE                 ? ST_ERR       :
                       dbg.iCMD_COMMAND == CMD_READ  ? ST_RD        :
                       dbg.iCMD_COMMAND == CMD_WRITE ? ST_WR_WAIT   :
                       dbg.iCMD_COMMAND == CMD_STEP  ? ST_STEP_WAIT : ST_CORE_WAIT;
            cmd_d    = dbg.iCMD_COMMAND;
            target_d = dbg.iCMD_TARGET;
            wdata_d  = dbg.iCMD_DATA;
            rdata_d  = sel_data;
            remain_d = step_cnt;
            done_d   = '0;
        end
        // Read data is captured at accept, so RD is itself the response cycle.
        case (state_q)
            ST_RD, ST_ERR, ST_RESP: state_d = ST_IDLE;
            ST_WR_WAIT:             state_d = dbg.iREG_W_ACK ? ST_RESP : ST_WR_WAIT;
            ST_CORE_WAIT: begin
                state_d   = dbg.iDEBUG_CORE_ACK ? ST_RESP : ST_CORE_WAIT;
                stopped_d = dbg.iDEBUG_CORE_ACK ? cmd_q == CMD_STOP : stopped_q;
            end
            ST_STEP_WAIT: begin
                if (dbg.iDEBUG_CORE_ACK) begin
                    state_d  = remain_q > P_STEP_W'(1) ? ST_STEP_GAP : ST_RESP;
                    remain_d = remain_q - P_STEP_W'(1);
                    done_d   = done_q + P_STEP_W'(1);
                end
            end
            ST_STEP_GAP:            state_d = ST_STEP_WAIT;
            default: ;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            target_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            remain_q  <= '0;
            done_q    <= '0;
            stopped_q <= P_STOPPED_AT_RESET;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            target_q  <= target_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            remain_q  <= remain_d;
            done_q    <= done_d;
            stopped_q <= stopped_d;
        end
    end

    assign dbg.oCMD_BUSY         = state_q != ST_IDLE;
    assign dbg.oRESP_VALID       = state_q == ST_RD || state_q == ST_ERR || state_q == ST_RESP;
    assign dbg.oRESP_ERROR       = state_q == ST_ERR;
    assign dbg.oRESP_DATA        = state_q == ST_RD ? rdata_q :
                                   (state_q == ST_RESP && cmd_q == CMD_STEP) ? P_DATA_W'(done_q) : '0;
    assign dbg.oDEBUG_CORE_REQ   = state_q == ST_CORE_WAIT || state_q == ST_STEP_WAIT;
    assign dbg.oDEBUG_CORE_START = state_q == ST_CORE_WAIT && cmd_q == CMD_GO;
    assign dbg.oDEBUG_CORE_STOP  = state_q == ST_CORE_WAIT && cmd_q == CMD_STOP;
    assign dbg.oDEBUG_CORE_STEP  = state_q == ST_STEP_WAIT;
    assign dbg.oREG_W_VALID      = state_q == ST_WR_WAIT;
    assign dbg.oREG_W_TARGET     = state_q == ST_WR_WAIT ? target_q : '0;
    assign dbg.oREG_W_DATA       = state_q == ST_WR_WAIT ? wdata_q : '0;
    assign dbg.oCORE_STOPPED     = stopped_q;

endmodule

// File: tb/tb_core_debug_unit.sv
// tb_core_debug_unit: scoreboard bench; expected responses are queued at issue and matched on oRESP_VALID.
module tb_core_debug_unit;

    localparam logic [3:0] OP_READ = 4'h0, OP_WRITE = 4'h1, OP_GO = 4'h8, OP_STEP = 4'hA, OP_STOP = 4'hF;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          core_delay = 0;
    int          w_delay = 0;
    int          core_cnt = 0;
    int          w_cnt = 0;
    int          n_req = 0;
    int          n_w = 0;
    int          n_step = 0;
    logic        prev_step = 1'b0;
    logic [11:0] exp_wt = '0;
    logic [31:0] exp_wd = '0;
    exp_t        sb[$];

    core_debug_if #(.P_DATA_W(32), .P_TARGET_W(12), .P_REG_N(38)) dbg ();

    core_debug_unit #(
        .P_DATA_W(32), .P_TARGET_W(12), .P_REG_N(38), .P_STEP_W(8), .P_STOPPED_AT_RESET(1'b0)
    ) dut (
        .iCLOCK (clk),
        .inRESET(rst_n),
        .dbg    (dbg.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Core and register-file responders: ack after a programmable number of request cycles.
    always @(negedge clk) begin
        if (dbg.oDEBUG_CORE_REQ) begin
            dbg.iDEBUG_CORE_ACK = core_cnt == core_delay;
            core_cnt++;
        end else begin
            dbg.iDEBUG_CORE_ACK = 1'b0;
            core_cnt = 0;
        end
        if (dbg.oREG_W_VALID) begin
            dbg.iREG_W_ACK = w_cnt == w_delay;
            w_cnt++;
        end else begin
            dbg.iREG_W_ACK = 1'b0;
            w_cnt = 0;
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (dbg.oRESP_VALID) begin
            if (sb.size() == 0) chk("unexpected_resp", 1'b1, 1'b0);
            else begin
                e = sb.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                chk("resp_error", dbg.oRESP_ERROR, e.err);
                chk("resp_data", dbg.oRESP_DATA, e.data);
            end
        end
        if (dbg.oDEBUG_CORE_REQ) n_req++;
        if (dbg.oREG_W_VALID) begin
            n_w++;
            chk("w_target", dbg.oREG_W_TARGET, exp_wt);
            chk("w_data", dbg.oREG_W_DATA, exp_wd);
        end
        if (dbg.oDEBUG_CORE_STEP && !prev_step) n_step++;
        prev_step = dbg.oDEBUG_CORE_STEP;
        if ((int'(dbg.oDEBUG_CORE_START) + int'(dbg.oDEBUG_CORE_STOP) + int'(dbg.oDEBUG_CORE_STEP) > 1) ||
            ((dbg.oDEBUG_CORE_START || dbg.oDEBUG_CORE_STOP || dbg.oDEBUG_CORE_STEP) && !dbg.oDEBUG_CORE_REQ))
            chk("qualifier_rule", 1'b1, 1'b0);
    end

    // lat < 0: no response is expected for this command.
    task automatic issue(input logic [3:0] c, input logic [11:0] t, input logic [31:0] d,
                         input int lat, input logic e, input logic [31:0] rd);
        @(negedge clk);
        if (lat >= 0) sb.push_back('{cyc + lat, e, rd});
        dbg.iCMD_REQ = 1'b1;
        dbg.iCMD_COMMAND = c;
        dbg.iCMD_TARGET = t;
        dbg.iCMD_DATA = d;
        @(negedge clk);
        dbg.iCMD_REQ = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || dbg.oCMD_BUSY) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n >= 60, 1'b0);
    endtask

    initial begin
        int r0, w0, s0;
        dbg.iCMD_REQ = 1'b0;
        dbg.iCMD_COMMAND = '0;
        dbg.iCMD_TARGET = '0;
        dbg.iCMD_DATA = '0;
        for (int k = 0; k < 38; k++)
            dbg.iREG_R_DATA[k*32 +: 32] = (k == 34) ? 32'h0000_1234 : 32'hA500_0000 + 32'(k);
        repeat (3) @(negedge clk);
        chk("rst_busy", dbg.oCMD_BUSY, 1'b0);
        chk("rst_resp_valid", dbg.oRESP_VALID, 1'b0);
        chk("rst_core_req", dbg.oDEBUG_CORE_REQ, 1'b0);
        chk("rst_w_valid", dbg.oREG_W_VALID, 1'b0);
        chk("rst_stopped", dbg.oCORE_STOPPED, 1'b0);
        rst_n = 1'b1;

        r0 = n_req;
        issue(OP_READ, 12'd3, 32'h0, 1, 1'b1, 32'h0);
        wait_idle();
        chk("read_running_noreq", 64'(n_req - r0), 64'd0);

        core_delay = 2;
        r0 = n_req;
        issue(OP_STOP, 12'd0, 32'h0, 4, 1'b0, 32'h0);
        wait_idle();
        chk("stop_req_cycles", 64'(n_req - r0), 64'd3);
        chk("stop_stopped", dbg.oCORE_STOPPED, 1'b1);

        issue(OP_READ, 12'd34, 32'h0, 1, 1'b0, 32'h0000_1234);
        wait_idle();

        w_delay = 4;
        exp_wt = 12'd5;
        exp_wd = 32'hDEAD_BEEF;
        w0 = n_w;
        r0 = n_req;
        issue(OP_WRITE, 12'd5, 32'hDEAD_BEEF, 6, 1'b0, 32'h0);
        chk("wr_busy_a", dbg.oCMD_BUSY, 1'b1);
        @(negedge clk);
        dbg.iCMD_REQ = 1'b1;
        dbg.iCMD_COMMAND = OP_GO;
        chk("wr_busy_b", dbg.oCMD_BUSY, 1'b1);
        @(negedge clk);
        dbg.iCMD_REQ = 1'b0;
        chk("wr_busy_c", dbg.oCMD_BUSY, 1'b1);
        wait_idle();
        chk("wr_valid_cycles", 64'(n_w - w0), 64'd5);
        chk("wr_ignored_req", 64'(n_req - r0), 64'd0);
        chk("wr_stopped", dbg.oCORE_STOPPED, 1'b1);

        core_delay = 0;
        s0 = n_step;
        issue(OP_STEP, 12'd0, 32'h0000_0003, 6, 1'b0, 32'd3);
        wait_idle();
        chk("step3_pulses", 64'(n_step - s0), 64'd3);
        chk("step3_stopped", dbg.oCORE_STOPPED, 1'b1);

        s0 = n_step;
        issue(OP_STEP, 12'd0, 32'hFFFF_FF00, 2, 1'b0, 32'd1);
        wait_idle();
        chk("step0_pulses", 64'(n_step - s0), 64'd1);

        r0 = n_req;
        issue(OP_READ, 12'd38, 32'h0, 1, 1'b1, 32'h0);
        wait_idle();
        issue(4'h9, 12'd0, 32'h0, 1, 1'b1, 32'h0);
        wait_idle();
        chk("err_noreq", 64'(n_req - r0), 64'd0);

        core_delay = 1;
        issue(OP_GO, 12'd0, 32'h0, 3, 1'b0, 32'h0);
        wait_idle();
        chk("go_running", dbg.oCORE_STOPPED, 1'b0);
        issue(OP_GO, 12'd0, 32'h0, 3, 1'b0, 32'h0);
        wait_idle();
        chk("go_again_running", dbg.oCORE_STOPPED, 1'b0);

        w0 = n_w;
        issue(OP_STEP, 12'd0, 32'd2, 1, 1'b1, 32'h0);
        wait_idle();
        issue(OP_WRITE, 12'd1, 32'h1, 1, 1'b1, 32'h0);
        wait_idle();
        chk("err_nowrite", 64'(n_w - w0), 64'd0);

        core_delay = 0;
        issue(OP_STOP, 12'd0, 32'h0, 2, 1'b0, 32'h0);
        wait_idle();
        w_delay = 10;
        exp_wt = 12'd7;
        exp_wd = 32'h0000_55AA;
        issue(OP_WRITE, 12'd7, 32'h0000_55AA, -1, 1'b0, 32'h0);
        chk("rstw_valid_before", dbg.oREG_W_VALID, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_valid_after", dbg.oREG_W_VALID, 1'b0);
        chk("rstw_resp", dbg.oRESP_VALID, 1'b0);
        chk("rstw_busy", dbg.oCMD_BUSY, 1'b0);
        chk("rstw_stopped", dbg.oCORE_STOPPED, 1'b0);
        rst_n = 1'b1;
        issue(OP_STOP, 12'd0, 32'h0, 2, 1'b0, 32'h0);
        wait_idle();
        issue(OP_READ, 12'd34, 32'h0, 1, 1'b0, 32'h0000_1234);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
